// File: rtl/sfp_out_drain.sv
// sfp_out_drain: drain stage for one core's out_sfp result rows.
// Buffers full col-wide rows in a small row FIFO and streams them to the
// result writer one column word per handshake, with back-pressure.
// Optional feature macro: SFP_DRAIN_SAT_EN clamps every output word to the
// signed bw-bit activation range and sign-extends it back to bw_psum bits.
module sfp_out_drain #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+3,
  parameter int depth   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic [col*bw_psum-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [bw_psum-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(col)-1:0] out_col,
  output logic                   out_last,
  output logic [15:0]            rows_done,
  output logic                   overflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(col);
  localparam logic [AW:0]   FULL_C     = (AW+1)'(depth);
  localparam logic [AW:0]   EMPTY_C    = (AW+1)'(0);
  localparam logic [CW-1:0] LAST_COL_C = CW'(col-1);

`ifdef SFP_DRAIN_SAT_EN
  localparam logic signed [bw_psum-1:0] SAT_MAX_C = bw_psum'((2**(bw-1))-1);
  localparam logic signed [bw_psum-1:0] SAT_MIN_C = ~SAT_MAX_C;

  // Clamp a two's complement column word to the signed bw-bit range.
  function automatic logic [bw_psum-1:0] sat_word(input logic [bw_psum-1:0] w);
    logic signed [bw_psum-1:0] s;
    s = signed'(w);
    if (s > SAT_MAX_C) begin
      return SAT_MAX_C;
    end else if (s < SAT_MIN_C) begin
      return SAT_MIN_C;
    end else begin
      return w;
    end
  endfunction
`endif

  // Row storage is deliberately not reset; outputs are gated by out_valid.
  logic [col*bw_psum-1:0] mem_r [depth];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            count_r;
  logic [CW-1:0]          out_col_r;
  logic [15:0]            rows_done_r;
  logic                   overflow_r;

  logic                   in_ready_s;
  logic                   out_valid_s;
  logic                   push_s;
  logic                   xfer_s;
  logic                   pop_s;
  logic [col*bw_psum-1:0] head_row_s;
  logic [bw_psum-1:0]     head_word_s;

  // Handshake decode from registered occupancy and column index only.
  always_comb begin
    in_ready_s  = (count_r != FULL_C);
    out_valid_s = (count_r != EMPTY_C);
    push_s      = in_valid && in_ready_s;
    xfer_s      = out_valid_s && out_ready;
    pop_s       = xfer_s && (out_col_r == LAST_COL_C);
  end

  // Column mux from the head row selected by the registered column index.
  always_comb begin
    head_row_s  = mem_r[rd_ptr_r];
    head_word_s = head_row_s[out_col_r*bw_psum +: bw_psum];
  end

  // Row write port; a cleared cycle never writes so storage stays as-is.
  always_ff @(posedge clk) begin
    if (push_s && !clr) begin
      mem_r[wr_ptr_r] <= in_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy, column index, row counter and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= EMPTY_C;
      out_col_r   <= CW'(0);
      rows_done_r <= 16'd0;
      overflow_r  <= 1'b0;
    end else if (clr) begin
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= EMPTY_C;
      out_col_r   <= CW'(0);
      rows_done_r <= 16'd0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (xfer_s) begin
        out_col_r <= (out_col_r == LAST_COL_C) ? CW'(0) : out_col_r + CW'(1);
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + AW'(1);
        rows_done_r <= rows_done_r + 16'd1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (in_valid && !in_ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Output drive; data and last are forced to zero while nothing is queued.
  always_comb begin
    in_ready  = in_ready_s;
    out_valid = out_valid_s;
    out_col   = out_col_r;
    rows_done = rows_done_r;
    overflow  = overflow_r;
    if (out_valid_s) begin
`ifdef SFP_DRAIN_SAT_EN
      out_data = sat_word(head_word_s);
`else
      out_data = head_word_s;
`endif
      out_last = (out_col_r == LAST_COL_C);
    end else begin
      out_data = {bw_psum{1'b0}};
      out_last = 1'b0;
    end
  end

endmodule
